// File: rtl/switch_press_decoder.sv
// Push-button front end: two-flop synchroniser, counter debouncer and a
// press classifier that emits short/long pulses, a held flag and a short-press count.
module switch_press_decoder #(
   parameter int DEBOUNCE_LIMIT = 250_000,
   parameter int LONG_PRESS     = 25_000_000
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_Switch_1,
   output logic       o_Switch,
   output logic       o_Press_Short,
   output logic       o_Press_Long,
   output logic       o_Held,
   output logic [7:0] o_Press_Count,
   output logic [1:0] o_State
);

   localparam int DW = $clog2(DEBOUNCE_LIMIT);
   localparam int HW = $clog2(LONG_PRESS);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_LIMIT - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PRESSED = 2'd1,
      S_LONG    = 2'd2
   } state_t;

   logic          sync_meta;
   logic          sync_sw;
   logic [DW-1:0] db_count;

   state_t        state, state_nxt;
   logic [HW-1:0] hold, hold_nxt;
   logic          short_nxt, long_nxt, held_nxt;
   logic [7:0]    count_nxt;

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         sync_meta <= 1'b0;
         sync_sw   <= 1'b0;
      end else begin
         sync_meta <= i_Switch_1;
         sync_sw   <= sync_meta;
      end
   end

   // Any sample matching the current level restarts the qualification window.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         db_count <= '0;
         o_Switch <= 1'b0;
      end else if (sync_sw == o_Switch) begin
         db_count <= '0;
      end else if (db_count == DB_LAST) begin
         db_count <= '0;
         o_Switch <= sync_sw;
      end else begin
         db_count <= db_count + DW'(1);
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state         <= S_IDLE;
         hold          <= '0;
         o_Press_Short <= 1'b0;
         o_Press_Long  <= 1'b0;
         o_Held        <= 1'b0;
         o_Press_Count <= 8'd0;
      end else begin
         state         <= state_nxt;
         hold          <= hold_nxt;
         o_Press_Short <= short_nxt;
         o_Press_Long  <= long_nxt;
         o_Held        <= held_nxt;
         o_Press_Count <= count_nxt;
      end
   end

   // Release is tested before the long threshold so a coincident release counts as short.
   always_comb begin
      state_nxt = state;
      hold_nxt  = hold;
      short_nxt = 1'b0;
      long_nxt  = 1'b0;
      held_nxt  = o_Held;
      count_nxt = o_Press_Count;
      case (state)
         S_IDLE: begin
            held_nxt = 1'b0;
            if (o_Switch) begin
               state_nxt = S_PRESSED;
               hold_nxt  = '0;
            end
         end
         S_PRESSED: begin
            if (!o_Switch) begin
               short_nxt = 1'b1;
               count_nxt = o_Press_Count + 8'd1;
               state_nxt = S_IDLE;
               hold_nxt  = hold + HW'(1);
            end else if (hold == HOLD_LAST) begin
               long_nxt  = 1'b1;
               held_nxt  = 1'b1;
               state_nxt = S_LONG;
            end else begin
               hold_nxt  = hold + HW'(1);
            end
         end
         S_LONG: begin
            held_nxt = 1'b1;
            if (!o_Switch) begin
               held_nxt  = 1'b0;
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            held_nxt  = 1'b0;
         end
      endcase
   end

   assign o_State = state;

endmodule

// File: doc/switch_press_decoder.md
Name: switch_press_decoder

Overview:
- Input-side counterpart to the LED blinker. Reads one raw push-button (active-high, asynchronous to i_Clk, bouncy), synchronises and debounces it, then classifies each press as short or long.
- Produces a debounced level, single-cycle event pulses, a held flag and a short-press counter.
- Sits between a board switch pin and downstream LED/control logic on the 25 MHz clock domain.

Parameters:
- DEBOUNCE_LIMIT, 250_000, number of consecutive cycles the synchronised input must differ from o_Switch before o_Switch follows it (10 ms at 25 MHz); must be ≥ 2.
- LONG_PRESS, 25_000_000, number of debounced-high cycles after which a press is classified long (1 s at 25 MHz); must be > DEBOUNCE_LIMIT.
- Counter widths are derived with $clog2 of each limit. Both parameters are overridable for simulation.

Ports:
- i_Clk  in  1  system clock, 25 MHz.
- i_Rst  in  1  synchronous reset, active-high.
- i_Switch_1  in  1  raw button, 1 = pressed, asynchronous.
- o_Switch  out  1  debounced level.
- o_Press_Short  out  1  one-cycle pulse: press released before long threshold.
- o_Press_Long  out  1  one-cycle pulse: long threshold reached while still pressed.
- o_Held  out  1  high from o_Press_Long cycle until release.
- o_Press_Count  out  8  count of short presses, wraps 255 -> 0.

Behaviour:
- Reset:
  - i_Rst sampled at posedge. While high, it clears: sync flops, debounce counter, hold counter, all outputs; FSM returns to S_IDLE.
  - Reset mid-press: no pulse is generated for that press. After reset, a still-pressed switch is treated as a new press and debounced from scratch.
- Synchroniser: two flops, reset value 0. The synchronised input lags i_Switch_1 by 2 cycles.
- Debounce:
  - Debounce counter clears to 0 on any cycle the synchronised input equals o_Switch; otherwise it increments.
  - On the edge where the counter == DEBOUNCE_LIMIT-1 and the input still differs, o_Switch toggles and the counter clears.
  - A single opposite sample restarts the count. Glitches shorter than DEBOUNCE_LIMIT cycles never reach o_Switch.
  - o_Switch changes exactly 2+DEBOUNCE_LIMIT cycles after a clean i_Switch_1 edge.
- Press FSM, driven only by o_Switch:
  - S_IDLE: on o_Switch=1, go to S_PRESSED and set hold counter to 0.
  - S_PRESSED: hold counter increments each cycle.
    - If o_Switch=0: assert o_Press_Short on the next cycle, increment o_Press_Count (mod 256), go to S_IDLE.
    - Else if hold counter == LONG_PRESS-1: assert o_Press_Long on the next cycle, set o_Held, go to S_LONG.
    - Release is checked first. If release and threshold coincide, the press is short.
  - S_LONG: o_Held=1. On o_Switch=0, clear o_Held, go to S_IDLE, no pulse, count unchanged.
- Output timing:
  - All pulse outputs are registered and high for exactly one cycle.
  - o_Press_Short is high the cycle after o_Switch is first seen low.
  - o_Press_Long and o_Held rise on the same cycle.
- Simultaneity: o_Press_Short and o_Press_Long are never high in the same cycle, and never more than one pulse per press.
- Hold counter saturates (does not wrap) in S_LONG; holding indefinitely produces no extra pulses.
- No combinational path from i_Switch_1 to any output.

Test Plan (DEBOUNCE_LIMIT=4, LONG_PRESS=20):
- Reset: hold i_Rst 3 cycles with i_Switch_1=1 -> all outputs 0 throughout. After release, o_Switch rises exactly 6 cycles later.
- Bounce rejection: i_Switch_1 pattern 1,0,1,1,0,1 (1 cycle each) then 0 -> o_Switch stays 0, no pulses, count 0.
- Short press: i_Switch_1 high 10 cycles, then low ->
  - o_Switch high 6 cycles after rise.
  - o_Press_Short one pulse; o_Press_Count 0->1.
  - o_Press_Long and o_Held stay 0.
- Long press: i_Switch_1 high 40 cycles ->
  - o_Press_Long pulses once, 20 cycles after o_Switch rises.
  - o_Held high until o_Switch falls.
  - No o_Press_Short; count unchanged.
- Boundary: release timed so o_Switch falls on the cycle the hold counter == 19 -> o_Press_Short pulses, o_Press_Long stays 0.
- Wrap and reset mid-press:
  - 256 short presses -> o_Press_Count returns to 0.
  - Assert i_Rst during S_PRESSED -> no pulse, count 0.
